mips_multicycle_control: RTL and testbench

Multicycle MIPS control unit. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath enables and mux selects for every state. It replaces the single-cycle opcode decoder in the multicycle processor variant. It adds a memory ready handshake, a configurable illegal-opcode trap, optional `addi` support and a retired-instruction counter.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/mips_multicycle_control_if.sv | 27 ++
 rtl/mc_ctrl_outdec.sv | 74 +++++++
 rtl/mips_multicycle_control.sv | 90 +++++++++
 tb/tb_mips_multicycle_control.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, FSM states,
// datapath mux encodings and the packed control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH     = 4'h0,
        S_DECODE    = 4'h1,
        S_MEM_ADDR  = 4'h2,
        S_MEM_READ  = 4'h3,
        S_MEM_WB    = 4'h4,
        S_MEM_WRITE = 4'h5,
        S_R_EXEC    = 4'h6,
        S_R_WB      = 4'h7,
        S_I_EXEC    = 4'h8,
        S_I_WB      = 4'h9,
        S_BRANCH    = 4'hA,
        S_JUMP      = 4'hB,
        S_TRAP      = 4'hF
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;
    typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} alu_src_b_t;
    typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10} pc_source_t;
    typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10} reg_dst_t;
    typedef enum logic [1:0] {WB_ALUOUT = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10} mem_to_reg_t;

    typedef struct packed {
        logic        pc_write;
        logic        pc_write_cond;
        logic        pc_write_cond_ne;
        logic        i_or_d;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        logic        reg_write;
        logic        alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        pc_source_t  pc_source;
        reg_dst_t    reg_dst;
        mem_to_reg_t mem_to_reg;
    } ctrl_word_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-unit <-> datapath bundle: IR opcode and memory ready in, enables/selects out.
interface mips_multicycle_control_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, PCWriteCondNe;
    logic             IorD, MemRead, MemWrite, IRWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg;
    logic             RegWrite;
    logic             illegal_op;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, RegWrite,
               illegal_op, state_o, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, RegWrite,
               illegal_op, state_o, instr_count
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: maps the current state (plus opcode and memory ready
// where a state needs them) to the datapath control word.
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_word_t cw
);
    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            S_DECODE:    cw.alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = WB_MDR;
                cw.reg_dst    = DST_RT;
            end
            S_MEM_WRITE: begin
                cw.mem_write = 1'b1;
                cw.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = DST_RD;
            end
            S_I_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
            end
            S_I_WB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = DST_RT;
            end
            S_BRANCH: begin
                cw.alu_src_a        = 1'b1;
                cw.alu_op           = ALUOP_SUB;
                cw.pc_source        = PCSRC_ALUOUT;
                cw.pc_write_cond    = (opcode == OP_BEQ);
                cw.pc_write_cond_ne = (opcode == OP_BNE);
            end
            S_JUMP: begin
                cw.pc_write  = 1'b1;
                cw.pc_source = PCSRC_JUMP;
                // jal links the return address into $31
                if (opcode == OP_JAL) begin
                    cw.reg_write  = 1'b1;
                    cw.reg_dst    = DST_RA;
                    cw.mem_to_reg = WB_PC;
                end
            end
            default: cw = '0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic, sticky
// illegal-opcode flag and retired-instruction counter.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit ADDI_EN         = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_multicycle_control_if.master bus
);
    state_t           state, state_nxt, illegal_tgt;
    logic             rdy;
    ctrl_word_t       cw, cw_out;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    assign rdy         = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    assign illegal_tgt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (rdy) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:           state_nxt = S_R_EXEC;
                    OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
                    OP_J, OP_JAL:   state_nxt = S_JUMP;
                    OP_ADDI:        state_nxt = ADDI_EN ? S_I_EXEC : illegal_tgt;
                    default:        state_nxt = illegal_tgt;
                endcase
            end
            S_MEM_ADDR:  state_nxt = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (rdy) state_nxt = S_MEM_WB;
            S_MEM_WRITE: if (rdy) state_nxt = S_FETCH;
            S_R_EXEC:    state_nxt = S_R_WB;
            S_I_EXEC:    state_nxt = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_TRAP) illegal_op <= 1'b1;
            // an instruction retires whenever the FSM comes back to FETCH
            if (state_nxt == S_FETCH && state != S_FETCH)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .opcode    (bus.opcode),
        .mem_ready (rdy),
        .cw        (cw)
    );

    // reset must silence the datapath immediately, not at the next edge
    assign cw_out = rst ? '0 : cw;

    assign bus.PCWrite       = cw_out.pc_write;
    assign bus.PCWriteCond   = cw_out.pc_write_cond;
    assign bus.PCWriteCondNe = cw_out.pc_write_cond_ne;
    assign bus.IorD          = cw_out.i_or_d;
    assign bus.MemRead       = cw_out.mem_read;
    assign bus.MemWrite      = cw_out.mem_write;
    assign bus.IRWrite       = cw_out.ir_write;
    assign bus.RegWrite      = cw_out.reg_write;
    assign bus.ALUSrcA       = cw_out.alu_src_a;
    assign bus.ALUSrcB       = cw_out.alu_src_b;
    assign bus.ALUOp         = cw_out.alu_op;
    assign bus.PCSource      = cw_out.pc_source;
    assign bus.RegDst        = cw_out.reg_dst;
    assign bus.MemtoReg      = cw_out.mem_to_reg;
    assign bus.illegal_op    = illegal_op;
    assign bus.state_o       = state;
    assign bus.instr_count   = instr_count;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control unit: default configuration, a
// no-addi/no-trap/4-bit-counter configuration and a no-handshake configuration.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rw_seen;

    mips_multicycle_control_if #(.CNT_W(32)) bus_a ();
    mips_multicycle_control_if #(.CNT_W(4))  bus_b ();
    mips_multicycle_control_if #(.CNT_W(32)) bus_c ();

    mips_multicycle_control dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

    mips_multicycle_control #(.ADDI_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    mips_multicycle_control #(.MEM_HANDSHAKE(1'b0))
        dut_c (.clk(clk), .rst(rst_c), .bus(bus_c));

    // {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite, RegWrite}
    logic [7:0] en_a, en_c;
    assign en_a = {bus_a.PCWrite, bus_a.PCWriteCond, bus_a.PCWriteCondNe, bus_a.IorD,
                   bus_a.MemRead, bus_a.MemWrite, bus_a.IRWrite, bus_a.RegWrite};
    assign en_c = {bus_c.PCWrite, bus_c.PCWriteCond, bus_c.PCWriteCondNe, bus_c.IorD,
                   bus_c.MemRead, bus_c.MemWrite, bus_c.IRWrite, bus_c.RegWrite};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.opcode = OP_LW;   bus_a.mem_ready = 1'b1;
        bus_b.opcode = OP_ADDI; bus_b.mem_ready = 1'b1;
        bus_c.opcode = OP_LW;   bus_c.mem_ready = 1'b0;
        rw_seen = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", bus_a.state_o, 32'h0);
        chk("rst_en", en_a, 32'h00);
        chk("rst_cnt", bus_a.instr_count, 32'h0);
        chk("rst_ill", bus_a.illegal_op, 32'h0);

        // lw, zero wait states
        rst_a = 1'b0;
        #1;
        chk("lw_fetch_en", en_a, 32'h8A);
        chk("lw_fetch_srcb", bus_a.ALUSrcB, 32'h1);
        step(); chk("lw_decode", bus_a.state_o, 32'h1);
        chk("lw_decode_srcb", bus_a.ALUSrcB, 32'h3);
        step(); chk("lw_memaddr", bus_a.state_o, 32'h2);
        chk("lw_memaddr_src", {bus_a.ALUSrcA, bus_a.ALUSrcB}, 32'h6);
        step(); chk("lw_memread", bus_a.state_o, 32'h3);
        chk("lw_memread_en", en_a, 32'h18);
        step(); chk("lw_memwb", bus_a.state_o, 32'h4);
        chk("lw_memwb_en", en_a, 32'h01);
        chk("lw_memwb_sel", {bus_a.MemtoReg, bus_a.RegDst}, 32'h4);
        step(); chk("lw_done_state", bus_a.state_o, 32'h0);
        chk("lw_count", bus_a.instr_count, 32'd1);

        // sw with two wait cycles in MEM_WRITE
        bus_a.opcode = OP_SW;
        step(); chk("sw_decode", bus_a.state_o, 32'h1);
        step(); chk("sw_memaddr", bus_a.state_o, 32'h2);
        step(); chk("sw_memwrite1", bus_a.state_o, 32'h5);
        bus_a.mem_ready = 1'b0;
        chk("sw_memwrite1_en", en_a, 32'h14);
        step(); chk("sw_memwrite2", {bus_a.state_o, en_a}, 32'h514);
        step(); chk("sw_memwrite3", {bus_a.state_o, en_a}, 32'h514);
        bus_a.mem_ready = 1'b1;
        step(); chk("sw_done_state", bus_a.state_o, 32'h0);
        chk("sw_count", bus_a.instr_count, 32'd2);

        // beq, bne, jal
        bus_a.opcode = OP_BEQ;
        step(); step();
        chk("beq_state", bus_a.state_o, 32'hA);
        chk("beq_en", en_a, 32'h40);
        chk("beq_sel", {bus_a.ALUSrcA, bus_a.ALUOp, bus_a.PCSource}, 32'h15);
        step(); chk("beq_count", {bus_a.state_o, bus_a.instr_count[7:0]}, 32'h003);
        bus_a.opcode = OP_BNE;
        step(); step();
        chk("bne_state", bus_a.state_o, 32'hA);
        chk("bne_en", en_a, 32'h20);
        step(); chk("bne_count", {bus_a.state_o, bus_a.instr_count[7:0]}, 32'h004);
        bus_a.opcode = OP_JAL;
        step(); step();
        chk("jal_state", bus_a.state_o, 32'hB);
        chk("jal_en", en_a, 32'h81);
        chk("jal_sel", {bus_a.RegDst, bus_a.MemtoReg, bus_a.PCSource}, 32'h2A);
        step(); chk("jal_count", {bus_a.state_o, bus_a.instr_count[7:0]}, 32'h005);

        // FETCH wait state
        bus_a.mem_ready = 1'b0;
        #1;
        chk("fetch_wait_en", en_a, 32'h08);
        step(); chk("fetch_wait_hold", {bus_a.state_o, bus_a.instr_count[7:0]}, 32'h005);
        bus_a.mem_ready = 1'b1;
        bus_a.opcode = 6'h3F;

        // illegal opcode traps and holds
        step(); chk("ill_decode", bus_a.state_o, 32'h1);
        step(); chk("trap_entry", {bus_a.state_o, en_a, bus_a.illegal_op}, 32'h1E01);
        for (int i = 0; i < 20; i++) begin
            bus_a.mem_ready = i[0];
            step();
            chk("trap_hold", {bus_a.state_o, en_a, bus_a.illegal_op}, 32'h1E01);
        end
        #2;
        rst_a = 1'b1;
        #1;
        chk("trap_rst_state", bus_a.state_o, 32'h0);
        chk("trap_rst_ill", bus_a.illegal_op, 32'h0);
        chk("trap_rst_en", en_a, 32'h00);
        chk("trap_rst_cnt", bus_a.instr_count, 32'h0);
        step();
        rst_a = 1'b0;
        bus_a.mem_ready = 1'b1;
        bus_a.opcode = OP_LW;

        // asynchronous reset in the middle of a MEM_READ wait
        step(); chk("mr_decode", bus_a.state_o, 32'h1);
        step(); chk("mr_memaddr", bus_a.state_o, 32'h2);
        bus_a.mem_ready = 1'b0;
        step(); chk("mr_memread", {bus_a.state_o, en_a}, 32'h318);
        step(); chk("mr_memread_wait", {bus_a.state_o, en_a}, 32'h318);
        #2;
        rst_a = 1'b1;
        #1;
        chk("mr_rst_en", en_a, 32'h00);
        chk("mr_rst_state", bus_a.state_o, 32'h0);
        step();

        // addi disabled, illegal retired as NOP, 4-bit counter wrap
        rst_b = 1'b0;
        #1;
        chk("nop_fetch", bus_b.state_o, 32'h0);
        step(); chk("nop_decode", bus_b.state_o, 32'h1);
        rw_seen = rw_seen | bus_b.RegWrite;
        step(); chk("nop_back", bus_b.state_o, 32'h0);
        chk("nop_count1", bus_b.instr_count, 32'h1);
        chk("nop_ill", bus_b.illegal_op, 32'h0);
        for (int i = 0; i < 14; i++) begin
            step(); rw_seen = rw_seen | bus_b.RegWrite;
            step(); rw_seen = rw_seen | bus_b.RegWrite;
        end
        chk("nop_count15", bus_b.instr_count, 32'hF);
        step(); step();
        chk("nop_wrap", bus_b.instr_count, 32'h0);
        chk("nop_regwrite", rw_seen, 32'h0);

        // handshake disabled: mem_ready held low is ignored
        rst_c = 1'b0;
        #1;
        chk("nohs_fetch_en", en_c, 32'h8A);
        step(); chk("nohs_decode", bus_c.state_o, 32'h1);
        step(); chk("nohs_memaddr", bus_c.state_o, 32'h2);
        step(); chk("nohs_memread", {bus_c.state_o, en_c}, 32'h318);
        step(); chk("nohs_memwb", bus_c.state_o, 32'h4);
        step(); chk("nohs_done", {bus_c.state_o, bus_c.instr_count[7:0]}, 32'h001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
